// File: rtl/median_line_buffer_pkg.sv
// median_line_buffer_pkg: shared defaults, row fill states and counter-width helper.
package median_line_buffer_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LINE_LEN = 8;
  typedef enum logic [1:0] {FILL0, FILL1, LIVE} row_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/median_line_buffer_if.sv
// median_line_buffer_if: pixel-in / row-triplet-out handshake bundle.
interface median_line_buffer_if #(parameter int WIDTH = median_line_buffer_pkg::DEF_WIDTH);
  logic flush, pix_valid, pix_ready, out_valid, out_ready;
  logic [WIDTH-1:0] pix_data, row0_data, row1_data, row2_data;
  modport master (output flush, pix_valid, pix_data, out_ready,
                  input pix_ready, out_valid, row0_data, row1_data, row2_data);
  modport slave (input flush, pix_valid, pix_data, out_ready,
                 output pix_ready, out_valid, row0_data, row1_data, row2_data);
endinterface

// File: rtl/median_line_buffer_line_mem.sv
// median_line_buffer_line_mem: one line of pixels, synchronous write, asynchronous read.
module median_line_buffer_line_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/median_line_buffer.sv
// median_line_buffer: turns a raster stream into column-aligned rows r-2, r-1, r.
module median_line_buffer
  import median_line_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LINE_LEN = DEF_LINE_LEN
) (
  input logic clk,
  input logic rst,
  median_line_buffer_if.slave bus
);
  localparam int CW = clog2(LINE_LEN);
  logic [CW-1:0] col, col_nxt;
  row_state_e row, row_nxt;
  logic acc, last, emit, out_valid;
  logic [WIDTH-1:0] a_q, b_q, r0, r1, r2;
  assign bus.pix_ready = !out_valid | bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.row0_data = r0;
  assign bus.row1_data = r1;
  assign bus.row2_data = r2;
  // Flush wins over accept: the pixel offered in a flush cycle is dropped.
  always_comb begin
    acc = bus.pix_valid & bus.pix_ready & !bus.flush;
    last = col == CW'(LINE_LEN - 1);
    emit = acc & (row == LIVE);
    col_nxt = bus.flush ? '0 : acc ? (last ? '0 : col + 1'b1) : col;
    row_nxt = bus.flush ? FILL0 :
              (acc & last & (row == FILL0)) ? FILL1 :
              (acc & last & (row == FILL1)) ? LIVE : row;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= FILL0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      out_valid <= !bus.flush & (emit | (out_valid & !bus.out_ready));
      if (emit) begin
        r0 <= a_q;
        r1 <= b_q;
        r2 <= bus.pix_data;
      end
    end
  end
  // A shifts down from B as B takes the new pixel, both reading before the write.
  median_line_buffer_line_mem #(.WIDTH(WIDTH), .DEPTH(LINE_LEN), .AW(CW)) mem_a (
    .clk(clk), .we(acc), .waddr(col), .raddr(col), .wdata(b_q), .rdata(a_q)
  );
  median_line_buffer_line_mem #(.WIDTH(WIDTH), .DEPTH(LINE_LEN), .AW(CW)) mem_b (
    .clk(clk), .we(acc), .waddr(col), .raddr(col), .wdata(bus.pix_data), .rdata(b_q)
  );
endmodule
